// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD sign reader: active-area size,
// RGB565 pixel type, default colours and the per-request pipeline tag.
package lcd_pkg;
  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;
  localparam int COORD_W  = 11;

  typedef logic [15:0]        rgb565_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam rgb565_t COLOR_FG_DEF = 16'hFFFF;
  localparam rgb565_t COLOR_BG_DEF = 16'h0000;

  typedef struct packed {
    logic in_win;
    logic inv;
  } px_tag_t;
endpackage

// File: rtl/lcd_sign_reader_if.sv
// Pixel request / response and sign ROM bus between LCD timing and the sign reader.
interface lcd_sign_reader_if #(
  parameter int ADDR_WIDTH = 17
);
  import lcd_pkg::*;

  logic                  frame_start;
  logic                  pixel_req;
  coord_t                pixel_x;
  coord_t                pixel_y;
  logic                  invert;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_data;
  rgb565_t               pixel_data;
  logic                  pixel_valid;
  logic                  addr_overrun;

  modport master (
    output frame_start, pixel_req, pixel_x, pixel_y, invert, rom_data,
    input  rom_addr, pixel_data, pixel_valid, addr_overrun
  );

  modport slave (
    input  frame_start, pixel_req, pixel_x, pixel_y, invert, rom_data,
    output rom_addr, pixel_data, pixel_valid, addr_overrun
  );
endinterface

// File: rtl/lcd_sign_addr_gen.sv
// Window compare and linear sign-ROM address generation, with a sticky flag for
// frames that request more in-window pixels than the sign holds.
module lcd_sign_addr_gen import lcd_pkg::*; #(
  parameter int ADDR_WIDTH = 17,
  parameter int IMG_X0     = 0,
  parameter int IMG_Y0     = 0,
  parameter int IMG_W      = 480,
  parameter int IMG_H      = 272
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pixel_req,
  input  coord_t                pixel_x,
  input  coord_t                pixel_y,
  output logic                  in_win,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  addr_overrun
);
  localparam coord_t                X0   = COORD_W'(IMG_X0);
  localparam coord_t                Y0   = COORD_W'(IMG_Y0);
  localparam coord_t                WW   = COORD_W'(IMG_W);
  localparam coord_t                HH   = COORD_W'(IMG_H);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  coord_t                dx, dy;
  logic [ADDR_WIDTH-1:0] cnt, base;
  logic                  hit, seen;

  // Unsigned offset wraps high when left of / above the window, so one compare per axis.
  assign dx     = pixel_x - X0;
  assign dy     = pixel_y - Y0;
  assign in_win = (dx < WW) && (dy < HH);
  assign base   = frame_start ? '0 : cnt;
  assign hit    = pixel_req && in_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rom_addr     <= '0;
      seen         <= 1'b0;
      addr_overrun <= 1'b0;
    end else begin
      if (hit) begin
        rom_addr <= base;
        cnt      <= (base == LAST) ? '0 : base + ADDR_WIDTH'(1);
      end else if (frame_start) begin
        cnt <= '0;
      end
      if (frame_start)  seen <= hit;
      else if (hit)     seen <= 1'b1;
      // Counter back at zero without a new frame means the raster outran the sign.
      if (hit && !frame_start && seen && (base == '0)) addr_overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/lcd_sign_reader.sv
// LCD sign reader: turns raster pixel requests into sign-ROM reads and RGB565
// pixels through a 3-stage pipeline (address, ROM read, colour).
module lcd_sign_reader import lcd_pkg::*; #(
  parameter int      ADDR_WIDTH = 17,
  parameter int      IMG_X0     = 0,
  parameter int      IMG_Y0     = 0,
  parameter int      IMG_W      = 480,
  parameter int      IMG_H      = 272,
  parameter rgb565_t FG_COLOR   = COLOR_FG_DEF,
  parameter rgb565_t BG_COLOR   = COLOR_BG_DEF
) (
  input logic               clk,
  input logic               rst,
  lcd_sign_reader_if.slave  bus
);
  localparam int STAGES = 3;

  if (IMG_W * IMG_H > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("lcd_sign_reader: IMG_W*IMG_H exceeds ROM address space");
  end
  if ((IMG_X0 + IMG_W > H_ACTIVE) || (IMG_Y0 + IMG_H > V_ACTIVE)) begin : g_bad_win
    $error("lcd_sign_reader: window exceeds active area");
  end

  logic            in_win;
  logic [STAGES:1] vld_pipe;
  px_tag_t         tag_s1, tag_s2;
  logic            fg_sel;
  rgb565_t         pix;

  lcd_sign_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMG_X0     (IMG_X0),
    .IMG_Y0     (IMG_Y0),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) u_addr (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (bus.frame_start),
    .pixel_req    (bus.pixel_req),
    .pixel_x      (bus.pixel_x),
    .pixel_y      (bus.pixel_y),
    .in_win       (in_win),
    .rom_addr     (bus.rom_addr),
    .addr_overrun (bus.addr_overrun)
  );

  // Outside the window the ROM bit is ignored; invert alone picks the colour.
  assign fg_sel = tag_s2.in_win ? (bus.rom_data ^ tag_s2.inv) : tag_s2.inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_s1   <= '0;
      tag_s2   <= '0;
      pix      <= BG_COLOR;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.pixel_req};
      tag_s1   <= '{in_win: in_win, inv: bus.invert};
      tag_s2   <= tag_s1;
      if (vld_pipe[STAGES-1]) pix <= fg_sel ? FG_COLOR : BG_COLOR;
    end
  end

  assign bus.pixel_data  = pix;
  assign bus.pixel_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_lcd_sign_reader.sv
// Directed bench: a full-screen reader and a 64x32 windowed reader share stimulus;
// each cycle checks pixel_valid timing, pixel_data and rom_addr against hand values.
module tb_lcd_sign_reader;
  import lcd_pkg::*;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  logic clk, rst, rom_force;
  int   ntest, nfail, nvf, nvw;

  logic [3:1]  evld;
  logic [15:0] epf [1:3];
  logic [15:0] epw [1:3];
  logic [15:0] lastf, lastw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_sign_reader_if #(.ADDR_WIDTH(17)) bf ();
  lcd_sign_reader_if #(.ADDR_WIDTH(11)) bw ();

  lcd_sign_reader dut_f (.clk(clk), .rst(rst), .bus(bf));
  lcd_sign_reader #(
    .ADDR_WIDTH(11), .IMG_X0(100), .IMG_Y0(50), .IMG_W(64), .IMG_H(32)
  ) dut_w (.clk(clk), .rst(rst), .bus(bw));

  // Sign ROM models: one-cycle registered read, mem[a] = a[0] unless forced to 1.
  always @(posedge clk) begin
    bf.rom_data <= rom_force | bf.rom_addr[0];
    bw.rom_data <= rom_force | bw.rom_addr[0];
  end

  function automatic logic [15:0] px(input logic b);
    return b ? FG : BG;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_model();
    evld  = '0;
    lastf = BG;
    lastw = BG;
    for (int i = 1; i <= 3; i++) begin
      epf[i] = BG;
      epw[i] = BG;
    end
  endtask

  task automatic drive(input logic r, input logic fs, input int x, input int y, input logic inv);
    bf.pixel_req = r;   bw.pixel_req = r;
    bf.frame_start = fs; bw.frame_start = fs;
    bf.pixel_x = 11'(x); bw.pixel_x = 11'(x);
    bf.pixel_y = 11'(y); bw.pixel_y = 11'(y);
    bf.invert = inv;    bw.invert = inv;
  endtask

  // One clock: drive a request, then check outputs #1 after the edge.
  task automatic cyc(input logic r, input logic fs, input int x, input int y, input logic inv,
                     input int af, input int aw, input logic [15:0] ef, input logic [15:0] ew);
    drive(r, fs, x, y, inv);
    @(posedge clk); #1;
    evld   = {evld[2:1], r};
    epf[3] = epf[2]; epf[2] = epf[1]; epf[1] = ef;
    epw[3] = epw[2]; epw[2] = epw[1]; epw[1] = ew;
    if (evld[3]) begin
      lastf = epf[3];
      lastw = epw[3];
    end
    chk("vld_f", 32'(bf.pixel_valid), 32'(evld[3]));
    chk("vld_w", 32'(bw.pixel_valid), 32'(evld[3]));
    chk("pix_f", 32'(bf.pixel_data), 32'(lastf));
    chk("pix_w", 32'(bw.pixel_data), 32'(lastw));
    if (af >= 0) chk("addr_f", 32'(bf.rom_addr), af);
    if (aw >= 0) chk("addr_w", 32'(bw.rom_addr), aw);
    nvf += int'(bf.pixel_valid);
    nvw += int'(bw.pixel_valid);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0, -1, -1, BG, BG);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_f", 32'(bf.rom_addr), 0);
    chk("rst_addr_w", 32'(bw.rom_addr), 0);
    chk("rst_pix_f",  32'(bf.pixel_data), 32'(BG));
    chk("rst_pix_w",  32'(bw.pixel_data), 32'(BG));
    chk("rst_vld_f",  32'(bf.pixel_valid), 0);
    chk("rst_vld_w",  32'(bw.pixel_valid), 0);
    chk("rst_ovr_f",  32'(bf.addr_overrun), 0);
    chk("rst_ovr_w",  32'(bw.addr_overrun), 0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    ntest = 0; nfail = 0; rom_force = 1'b0;

    // Raster the first 4 full rows back to back; window reader sees only out-of-window.
    do_rst();
    nvf = 0; nvw = 0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 480; x++)
        cyc(1'b1, 1'b0, x, y, 1'b0, y * 480 + x, 0, px(x[0]), BG);
    idle(4);
    chk("nvalid_f", 32'(nvf), 1920);
    chk("nvalid_w", 32'(nvw), 1920);

    // frame_start with a request at cnt=500, then frame_start alone.
    do_rst();
    for (int i = 0; i < 500; i++)
      cyc(1'b1, 1'b0, i % 480, i / 480, 1'b0, i, 0, px(i[0]), BG);
    cyc(1'b1, 1'b1, 5, 5, 1'b0, 0, 0, BG, BG);
    cyc(1'b1, 1'b0, 6, 5, 1'b0, 1, 0, FG, BG);
    chk("fs_ovr_f", 32'(bf.addr_overrun), 0);
    cyc(1'b0, 1'b1, 0, 0, 1'b0, 1, 0, BG, BG);
    cyc(1'b1, 1'b0, 7, 5, 1'b0, 0, 0, BG, BG);
    chk("fs_ovr_f2", 32'(bf.addr_overrun), 0);
    idle(4);

    // Window edges at X0=100,Y0=50,W=64,H=32.
    do_rst();
    cyc(1'b1, 1'b0,  99, 50, 1'b0, 0, 0, BG, BG);
    cyc(1'b1, 1'b0, 100, 50, 1'b0, 1, 0, FG, BG);
    cyc(1'b1, 1'b0, 101, 50, 1'b0, 2, 1, BG, FG);
    cyc(1'b1, 1'b0, 164, 50, 1'b0, 3, 1, FG, BG);
    cyc(1'b1, 1'b0, 100, 82, 1'b0, 4, 1, BG, BG);
    cyc(1'b1, 1'b0, 163, 81, 1'b0, 5, 2, FG, BG);
    cyc(1'b1, 1'b0, 100, 49, 1'b0, 6, 2, BG, BG);
    idle(4);

    // Invert with ROM forced to 1, inside and outside the window.
    rom_force = 1'b1;
    do_rst();
    cyc(1'b1, 1'b0,   0,  0, 1'b1, 0, 0, BG, FG);
    cyc(1'b1, 1'b0, 120, 60, 1'b1, 1, 0, BG, BG);
    cyc(1'b1, 1'b0,   0,  0, 1'b0, 2, 0, FG, BG);
    cyc(1'b1, 1'b0, 121, 60, 1'b0, 3, 1, FG, FG);
    idle(4);
    rom_force = 1'b0;

    // Full window frame, then a second frame without frame_start: wrap and overrun.
    do_rst();
    idx = 0;
    for (int y = 50; y < 82; y++)
      for (int x = 100; x < 164; x++) begin
        cyc(1'b1, 1'b0, x, y, 1'b0, idx, idx, px(idx[0]), px(idx[0]));
        idx++;
      end
    chk("wrap_pre_ovr_w", 32'(bw.addr_overrun), 0);
    cyc(1'b1, 1'b0, 100, 50, 1'b0, 2048, 0, BG, BG);
    chk("wrap_ovr_w", 32'(bw.addr_overrun), 1);
    chk("wrap_ovr_f", 32'(bf.addr_overrun), 0);
    for (int k = 1; k < 9; k++)
      cyc(1'b1, 1'b0, 100 + k, 50, 1'b0, 2048 + k, k, px(k[0]), px(k[0]));
    cyc(1'b0, 1'b1, 0, 0, 1'b0, -1, -1, BG, BG);
    cyc(1'b1, 1'b0, 100, 50, 1'b0, 0, 0, BG, BG);
    chk("sticky_ovr_w", 32'(bw.addr_overrun), 1);
    idle(4);

    // Reset with three requests in flight.
    do_rst();
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, BG, BG);
    cyc(1'b1, 1'b0, 1, 0, 1'b0, 1, 0, FG, BG);
    cyc(1'b1, 1'b0, 2, 0, 1'b0, 2, 0, BG, BG);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    #1;
    chk("async_vld_f",  32'(bf.pixel_valid), 0);
    chk("async_vld_w",  32'(bw.pixel_valid), 0);
    chk("async_addr_f", 32'(bf.rom_addr), 0);
    clr_model();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 3, 0, 1'b0, 0, 0, BG, BG);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
